microwave_cook_ctrl: RTL and testbench

Cook-cycle controller for the microwave. It consumes the one-cycle `tick` pulse from the clock divider and keeps a four-digit BCD MM:SS cook timer, loaded from the keypad. It sequences the magnetron enable through idle, cook, pause and done states, and drives the door interlock, end-of-cycle pulse and buzzer. It sits between the keypad/door inputs, the divider and the display/power drivers.

---
 rtl/microwave_cook_ctrl.sv | 144 ++++++++++++++
 tb/tb_microwave_cook_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_cook_ctrl.sv
// Microwave cook-cycle controller: keypad-loaded BCD MM:SS timer, magnetron
// sequencing through IDLE/COOK/PAUSED/DONE, door interlock and end-of-cycle buzzer.
module microwave_cook_ctrl #(
    parameter int TICKS_PER_SEC = 100,
    parameter int BEEP_SECS     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       mag_on,
    output logic       buzzer,
    output logic       done,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COOK   = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_SEC - 1);
    localparam logic [3:0] BEEP_LAST  = 4'(BEEP_SECS - 1);

    state_t      cur;
    logic [15:0] digits;
    logic [7:0]  presc;
    logic [3:0]  beep_cnt;

    logic        sec_evt;
    logic        time_zero;
    logic [7:0]  presc_adv;
    logic [15:0] dec_digits;

    // One-second BCD countdown; seconds above 59 simply count down in place.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    assign sec_evt    = tick && (presc == PRESC_LAST);
    assign presc_adv  = sec_evt ? 8'd0 : presc + 8'd1;
    assign time_zero  = (digits == 16'h0000);
    assign dec_digits = bcd_dec(digits);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= IDLE;
            digits   <= 16'h0000;
            presc    <= 8'd0;
            beep_cnt <= 4'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (cur)
                IDLE: begin
                    if (stop_clear) begin
                        digits <= 16'h0000;
                    end else if (start && door_closed && !time_zero) begin
                        cur   <= COOK;
                        presc <= 8'd0;
                    end else if (key_valid && (key_digit <= 4'd9)) begin
                        digits <= {digits[11:0], key_digit};
                    end
                end
                COOK: begin
                    // Interlock: an open door or stop freezes the partial second.
                    if (!door_closed || stop_clear) begin
                        cur <= PAUSED;
                    end else if (tick) begin
                        presc <= presc_adv;
                        if (sec_evt && !time_zero) begin
                            digits <= dec_digits;
                            if (dec_digits == 16'h0000) begin
                                cur      <= DONE;
                                done     <= 1'b1;
                                presc    <= 8'd0;
                                beep_cnt <= 4'd0;
                            end
                        end
                    end
                end
                PAUSED: begin
                    if (stop_clear) begin
                        cur    <= IDLE;
                        digits <= 16'h0000;
                    end else if (start && door_closed) begin
                        cur <= COOK;
                    end
                end
                DONE: begin
                    if (stop_clear || !door_closed) begin
                        cur <= IDLE;
                    end else if (tick) begin
                        presc <= presc_adv;
                        if (sec_evt) begin
                            beep_cnt <= beep_cnt + 4'd1;
                            if (beep_cnt == BEEP_LAST) begin
                                cur <= IDLE;
                            end
                        end
                    end
                end
                default: cur <= IDLE;
            endcase
        end
    end

    assign min_tens = digits[15:12];
    assign min_ones = digits[11:8];
    assign sec_tens = digits[7:4];
    assign sec_ones = digits[3:0];
    assign state    = cur;
    assign mag_on   = (cur == COOK);
    assign buzzer   = (cur == DONE);

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// Bench for microwave_cook_ctrl: two instances (TPS=1/BEEP=3 and TPS=4/BEEP=2),
// directed scenarios plus random stimulus against a decimal-arithmetic model.
module tb_microwave_cook_ctrl;

    logic       clk = 1'b0;
    logic       rst, tick, key_valid, start, stop_clear, door_closed;
    logic [3:0] key_digit;

    logic [3:0]  mt [2], mo [2], st [2], so [2];
    logic        mag [2], buz [2], dn [2];
    logic [1:0]  sta [2];
    logic [15:0] dig [2];
    logic [20:0] obs [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        microwave_cook_ctrl #(
            .TICKS_PER_SEC(g == 0 ? 1 : 4),
            .BEEP_SECS    (g == 0 ? 3 : 2)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .key_valid  (key_valid),
            .key_digit  (key_digit),
            .start      (start),
            .stop_clear (stop_clear),
            .door_closed(door_closed),
            .min_tens   (mt[g]),
            .min_ones   (mo[g]),
            .sec_tens   (st[g]),
            .sec_ones   (so[g]),
            .mag_on     (mag[g]),
            .buzzer     (buz[g]),
            .done       (dn[g]),
            .state      (sta[g])
        );
        assign dig[g] = {mt[g], mo[g], st[g], so[g]};
        assign obs[g] = {sta[g], mag[g], buz[g], dn[g], dig[g]};
    end

    // Reference model: the timer is held as the decimal number MMSS (0..9999).
    typedef struct packed {
        int st;
        int n;
        int presc;
        int beeps;
        bit done;
    } model_t;

    model_t m [2];

    function automatic model_t mstep(model_t c, int tps, int bs, bit tk, bit kv,
                                     int kd, bit strt, bit sc, bit door);
        model_t r;
        bit sec;
        r = c;
        r.done = 1'b0;
        sec = tk && (c.presc == tps - 1);
        if (c.st == 0) begin
            if (sc) r.n = 0;
            else if (strt && door && c.n != 0) begin r.st = 1; r.presc = 0; end
            else if (kv && kd <= 9) r.n = (c.n * 10 + kd) % 10000;
        end else if (c.st == 1) begin
            if (!door || sc) r.st = 2;
            else if (tk) begin
                r.presc = sec ? 0 : c.presc + 1;
                if (sec) begin
                    // MM:00 -> (MM-1):59 is a step of 41 in MMSS form.
                    r.n = (c.n % 100 != 0) ? c.n - 1 : c.n - 41;
                    if (r.n == 0) begin r.st = 3; r.done = 1'b1; r.presc = 0; r.beeps = 0; end
                end
            end
        end else if (c.st == 2) begin
            if (sc) begin r.st = 0; r.n = 0; end
            else if (strt && door) r.st = 1;
        end else begin
            if (sc || !door) r.st = 0;
            else if (tk) begin
                r.presc = sec ? 0 : c.presc + 1;
                if (sec) begin
                    r.beeps = c.beeps + 1;
                    if (r.beeps >= bs) r.st = 0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [20:0] expv(model_t c);
        logic [15:0] d;
        d = {4'(c.n / 1000), 4'((c.n / 100) % 10), 4'((c.n / 10) % 10), 4'(c.n % 10)};
        return {2'(c.st), c.st == 1, c.st == 3, c.done, d};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m[0] <= '0;
            m[1] <= '0;
        end else begin
            m[0] <= mstep(m[0], 1, 3, tick, key_valid, int'(key_digit), start, stop_clear, door_closed);
            m[1] <= mstep(m[1], 4, 2, tick, key_valid, int'(key_digit), start, stop_clear, door_closed);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(); rst = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1; key_digit = d; cyc(); key_valid = 1'b0; key_digit = 4'd0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin tick = 1'b1; cyc(); tick = 1'b0; end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== 21'd0) begin
                errors++; $display("FAIL reset_state inst=%0d got=%h exp=%h", i, obs[i], 21'd0);
            end
        end
    endtask

    task automatic test_keypad();
        do_reset();
        key(4'd1); key(4'd3); key(4'd0);
        checks++;
        if (dig[0] !== 16'h0130) begin errors++; $display("FAIL keypad_entry got=%h exp=%h", dig[0], 16'h0130); end
        key(4'd12);
        checks++;
        if (dig[0] !== 16'h0130) begin errors++; $display("FAIL keypad_ignore12 got=%h exp=%h", dig[0], 16'h0130); end
        key(4'd4); key(4'd2);
        checks++;
        if (dig[0] !== 16'h3042) begin errors++; $display("FAIL keypad_shiftout got=%h exp=%h", dig[0], 16'h3042); end
        stop_clear = 1'b1; cyc(); stop_clear = 1'b0;
        checks++;
        if (dig[0] !== 16'h0000) begin errors++; $display("FAIL keypad_clear got=%h exp=%h", dig[0], 16'h0000); end
    endtask

    task automatic test_full_cycle();
        do_reset();
        key(4'd5);
        pulse_start();
        checks++;
        if (sta[0] !== 2'd1 || mag[0] !== 1'b1) begin
            errors++; $display("FAIL cycle_start got state=%0d mag=%b exp state=1 mag=1", sta[0], mag[0]);
        end
        for (int k = 4; k >= 0; k--) begin
            ticks(1);
            checks++;
            if (so[0] !== 4'(k)) begin errors++; $display("FAIL cycle_sec_ones got=%0d exp=%0d", so[0], k); end
        end
        checks++;
        if ({sta[0], mag[0], buz[0], dn[0], dig[0]} !== {2'd3, 1'b0, 1'b1, 1'b1, 16'h0000}) begin
            errors++; $display("FAIL cycle_done got state=%0d mag=%b buz=%b done=%b dig=%h exp 3/0/1/1/0000",
                               sta[0], mag[0], buz[0], dn[0], dig[0]);
        end
        cyc();
        checks++;
        if (dn[0] !== 1'b0 || sta[0] !== 2'd3) begin
            errors++; $display("FAIL cycle_done_once got done=%b state=%0d exp done=0 state=3", dn[0], sta[0]);
        end
        ticks(2);
        checks++;
        if (sta[0] !== 2'd3 || buz[0] !== 1'b1) begin
            errors++; $display("FAIL cycle_beeping got state=%0d buz=%b exp 3/1", sta[0], buz[0]);
        end
        ticks(1);
        checks++;
        if (sta[0] !== 2'd0 || buz[0] !== 1'b0) begin
            errors++; $display("FAIL cycle_beep_end got state=%0d buz=%b exp 0/0", sta[0], buz[0]);
        end
    endtask

    task automatic test_borrow();
        logic [15:0] exp_d [3];
        exp_d[0] = 16'h0059; exp_d[1] = 16'h0959; exp_d[2] = 16'h0074;
        for (int c = 0; c < 3; c++) begin
            do_reset();
            if (c == 0) begin key(4'd1); key(4'd0); key(4'd0); end
            else if (c == 1) begin key(4'd1); key(4'd0); key(4'd0); key(4'd0); end
            else begin key(4'd7); key(4'd5); end
            pulse_start();
            ticks(1);
            checks++;
            if (dig[0] !== exp_d[c]) begin errors++; $display("FAIL borrow case=%0d got=%h exp=%h", c, dig[0], exp_d[c]); end
        end
    endtask

    task automatic test_prescaler_pause();
        do_reset();
        key(4'd1); key(4'd0);
        pulse_start();
        ticks(2);
        door_closed = 1'b0; cyc();
        checks++;
        if (sta[1] !== 2'd2 || mag[1] !== 1'b0) begin
            errors++; $display("FAIL pause_door got state=%0d mag=%b exp 2/0", sta[1], mag[1]);
        end
        ticks(10);
        checks++;
        if (dig[1] !== 16'h0010 || sta[1] !== 2'd2) begin
            errors++; $display("FAIL pause_hold got dig=%h state=%0d exp 0010/2", dig[1], sta[1]);
        end
        door_closed = 1'b1;
        pulse_start();
        checks++;
        if (sta[1] !== 2'd1) begin errors++; $display("FAIL pause_resume got state=%0d exp=1", sta[1]); end
        ticks(1);
        checks++;
        if (dig[1] !== 16'h0010) begin errors++; $display("FAIL presc_partial got=%h exp=%h", dig[1], 16'h0010); end
        ticks(1);
        checks++;
        if (dig[1] !== 16'h0009) begin errors++; $display("FAIL presc_kept got=%h exp=%h", dig[1], 16'h0009); end
    endtask

    task automatic test_rejects();
        do_reset();
        key(4'd3);
        door_closed = 1'b0; pulse_start(); door_closed = 1'b1;
        checks++;
        if (sta[0] !== 2'd0) begin errors++; $display("FAIL reject_door_open got state=%0d exp=0", sta[0]); end
        stop_clear = 1'b1; cyc(); stop_clear = 1'b0;
        pulse_start();
        checks++;
        if (sta[0] !== 2'd0) begin errors++; $display("FAIL reject_zero got state=%0d exp=0", sta[0]); end
        key(4'd2); key(4'd0);
        pulse_start();
        stop_clear = 1'b1; cyc(); stop_clear = 1'b0;
        checks++;
        if (sta[0] !== 2'd2) begin errors++; $display("FAIL stop_pauses got state=%0d exp=2", sta[0]); end
        start = 1'b1; stop_clear = 1'b1; cyc(); start = 1'b0; stop_clear = 1'b0;
        checks++;
        if (sta[0] !== 2'd0 || dig[0] !== 16'h0000) begin
            errors++; $display("FAIL clear_beats_start got state=%0d dig=%h exp 0/0000", sta[0], dig[0]);
        end
        key(4'd2); key(4'd0);
        pulse_start();
        door_closed = 1'b0; tick = 1'b1; cyc(); tick = 1'b0; door_closed = 1'b1;
        checks++;
        if (sta[0] !== 2'd2 || dig[0] !== 16'h0020) begin
            errors++; $display("FAIL interlock_wins got state=%0d dig=%h exp 2/0020", sta[0], dig[0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        key(4'd2); key(4'd1); key(4'd5);
        pulse_start();
        checks++;
        if (sta[0] !== 2'd1 || dig[0] !== 16'h0215) begin
            errors++; $display("FAIL mid_cook got state=%0d dig=%h exp 1/0215", sta[0], dig[0]);
        end
        rst = 1'b1; tick = 1'b1; start = 1'b1; key_valid = 1'b1; key_digit = 4'd7;
        cyc();
        rst = 1'b0; tick = 1'b0; start = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== 21'd0) begin errors++; $display("FAIL reset_mid inst=%0d got=%h exp=%h", i, obs[i], 21'd0); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst         = ($urandom_range(0, 99) == 0);
            tick        = ($urandom_range(0, 1) == 1);
            key_valid   = ($urandom_range(0, 3) == 0);
            key_digit   = 4'($urandom_range(0, 15));
            start       = ($urandom_range(0, 7) == 0);
            stop_clear  = ($urandom_range(0, 39) == 0);
            door_closed = ($urandom_range(0, 15) != 0);
            cyc();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== expv(m[i])) begin
                    errors++; $display("FAIL random inst=%0d cyc=%0d got=%h exp=%h", i, c, obs[i], expv(m[i]));
                end
            end
        end
        rst = 1'b0; tick = 1'b0; key_valid = 1'b0; start = 1'b0; stop_clear = 1'b0; door_closed = 1'b1;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
        start = 1'b0; stop_clear = 1'b0; door_closed = 1'b1;
        test_reset();
        test_keypad();
        test_full_cycle();
        test_borrow();
        test_prescaler_pause();
        test_rejects();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
